tt3_sweep_ctrl: RTL and testbench

Sequencer that characterises a 3-input truth-table logic gate (the `m0xNN` family, e.g. 0x1F). It steps the gate's `in1`/`in2`/`in3` through all eight input combinations 000→111. For each combination it holds the inputs for a programmable settle time, then samples the gate's `out`. It assembles the observed 8-bit truth-table code and compares it against an expected code. It sits between a test/config host and one gate instance, and is the only driver of that gate's inputs.

---
 rtl/tt3_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tt3_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt3_sweep_ctrl.sv
// tt3_sweep_ctrl
//
// Characterises one 3-input truth-table gate (m0xNN family). The gate inputs
// step through the combinations 000..111. Each combination is held for
// SETTLE_CYCLES cycles, and then the gate output is sampled. The observed
// 8-bit code is assembled and compared with the expected code latched at
// start. Combination 000 lands in the MSB, so a gate that is high for
// 011..111 reads back as 8'h1F.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   begin a sweep (honoured in IDLE only; beats abort there)
//   abort        in   cancel a sweep in progress (ignored in IDLE)
//   expected[8]  in   expected truth-table code, latched on accepted start
//   dut_out      in   gate output
//   in1/in2/in3  out  gate inputs (in1 is the MSB of the combination)
//   busy         out  sweep in progress
//   done         out  one-cycle pulse on normal completion
//   pass         out  table_code == latched expected; valid after done
//   table_code   out  observed truth-table code. The port is not named
//                     `table` because that word is reserved in the language.
//
// All outputs are registers. No input reaches an output combinationally.

module tt3_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_code
);

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] ins, ins_n;
  logic [7:0] tbl_n;
  logic [7:0] exp_q, exp_n;
  logic       pass_n, busy_n, done_n;

  // Insert the sample for combination k at bit position 7-k.
  function automatic logic [7:0] with_sample(input logic [7:0] t,
                                             input logic [2:0] k,
                                             input logic       b);
    logic [7:0] r;
    r = t;
    r[3'd7 - k] = b;
    return r;
  endfunction

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    ins_n   = ins;
    tbl_n   = table_code;
    exp_n   = exp_q;
    pass_n  = pass;
    busy_n  = busy;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          idx_n   = 3'd0;
          cnt_n   = CNT_RELOAD;
          ins_n   = 3'd0;
          tbl_n   = 8'h00;
          pass_n  = 1'b0;
          exp_n   = expected;
          busy_n  = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          // Abort beats the sample edge. Partial table bits are kept.
          state_n = IDLE;
          idx_n   = 3'd0;
          cnt_n   = 8'd0;
          ins_n   = 3'd0;
          busy_n  = 1'b0;
        end else if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          tbl_n = with_sample(table_code, idx, dut_out);
          if (idx == 3'd7) begin
            state_n = FINISH;
            ins_n   = 3'd0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            cnt_n = CNT_RELOAD;
            ins_n = idx + 3'd1;
          end
        end
      end

      FINISH: begin
        // table_code already holds the final sample taken on the entry edge.
        state_n = IDLE;
        idx_n   = 3'd0;
        busy_n  = 1'b0;
        if (!abort) begin
          pass_n = (table_code == exp_q);
        end
      end

      default: begin
        state_n = IDLE;
        idx_n   = 3'd0;
        cnt_n   = 8'd0;
        ins_n   = 3'd0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= 8'd0;
      ins        <= 3'd0;
      table_code <= 8'h00;
      pass       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      ins        <= ins_n;
      table_code <= tbl_n;
      pass       <= pass_n;
      busy       <= busy_n;
      done       <= done_n;
    end
    exp_q <= exp_n;
  end

  assign in1 = ins[2];
  assign in2 = ins[1];
  assign in3 = ins[0];

endmodule

// File: tb/tb_tt3_sweep_ctrl.sv
module tb_tt3_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [7:0] exp_in;
  logic [2:0] dout_v;
  logic [2:0] in1_v, in2_v, in3_v;
  logic [2:0] busy_v, done_v, pass_v;
  logic [7:0] tbl_v [3];
  logic [7:0] gf    [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three controllers with different settle times. Instance 0 drives a
  // zero-delay gate. Instances 1 and 2 drive a gate whose output lags by
  // two register stages.
  for (genvar g = 0; g < 3; g++) begin : gi
    logic comb_o, p1, p2;

    tt3_sweep_ctrl #(.SETTLE_CYCLES(g == 0 ? 4 : (g == 1 ? 1 : 3))) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start_v[g]),
      .abort     (abort_v[g]),
      .expected  (exp_in),
      .dut_out   (dout_v[g]),
      .in1       (in1_v[g]),
      .in2       (in2_v[g]),
      .in3       (in3_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .pass      (pass_v[g]),
      .table_code(tbl_v[g])
    );

    assign comb_o = gf[g][7 - int'({in1_v[g], in2_v[g], in3_v[g]})];

    always_ff @(posedge clk) begin
      p1 <= comb_o;
      p2 <= p1;
    end

    assign dout_v[g] = (g == 0) ? comb_o : p2;
  end

  function automatic int s_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic int d_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Reference model. The sample for combination k is taken on edge
  // E0+(k+1)*s. A gate with d extra register stages presents, just before
  // that edge, f applied to the inputs of the cycle that starts
  // (k+1)*s-1-d cycles after E0. Cycles before E0 are idle, so they show
  // combination 000. Only samples taken on edges before `lim` are kept.
  function automatic logic [7:0] model_tbl(int s, int d, logic [7:0] f, int lim);
    logic [7:0] t;
    int j;
    t = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if ((k + 1) * s < lim) begin
        j = (k + 1) * s - 1 - d;
        if (j < 0) j = 0;
        else j = j / s;
        t[7 - k] = f[7 - j];
      end
    end
    return t;
  endfunction

  task automatic chk(string tag, int i, logic [7:0] obs, logic [7:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, expv);
      end
  endtask

  task automatic idle_chk(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("idle_done", i, 8'(done_v[i]), 8'h00);
        chk("idle_busy", i, 8'(busy_v[i]), 8'h00);
      end
    end
  endtask

  // The task starts at a negedge and ends at the negedge after the
  // terminating edge. `ab`, `rs` and `rst2` are edge offsets from E0 for
  // abort, reset and a repeated start (0 = none).
  task automatic sweep(int i, logic [7:0] expv, int ab, int rs, int rst2, bit with_abort);
    int s, endc, lim;
    logic [7:0] ref_t;
    logic ref_p;
    s    = s_of(i);
    lim  = (ab > 0) ? ab : ((rs > 0) ? rs : 1000);
    endc = (ab > 0) ? ab : ((rs > 0) ? rs : 8 * s + 1);
    ref_t = (rs > 0) ? 8'h00 : model_tbl(s, d_of(i), gf[i], lim);
    ref_p = (ab == 0 && rs == 0) && (ref_t == expv);

    start_v[i] = 1'b1;
    exp_in     = expv;
    abort_v[i] = with_abort;
    @(negedge clk);
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
    exp_in     = 8'($urandom);

    for (int c = 0; c < endc; c++) begin
      if (c == 0) begin
        chk("clr_tbl", i, tbl_v[i], 8'h00);
        chk("clr_pass", i, 8'(pass_v[i]), 8'h00);
      end
      if (c < 8 * s) begin
        chk("busy", i, 8'(busy_v[i]), 8'h01);
        chk("done_early", i, 8'(done_v[i]), 8'h00);
        chk("inputs", i, 8'({in1_v[i], in2_v[i], in3_v[i]}), 8'(c / s));
      end else begin
        chk("done_pulse", i, 8'(done_v[i]), 8'h01);
      end
      start_v[i] = (rst2 == c + 1);
      abort_v[i] = (ab == c + 1);
      reset      = (rs == c + 1);
      @(negedge clk);
    end
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
    reset      = 1'b0;

    chk("end_busy", i, 8'(busy_v[i]), 8'h00);
    chk("end_done", i, 8'(done_v[i]), 8'h00);
    chk("end_inputs", i, 8'({in1_v[i], in2_v[i], in3_v[i]}), 8'h00);
    chk("end_tbl", i, tbl_v[i], ref_t);
    chk("end_pass", i, 8'(pass_v[i]), 8'(ref_p));
  endtask

  initial begin
    int i, ab, rst2;
    logic [7:0] mt, ev;

    reset   = 1'b1;
    start_v = 3'b000;
    abort_v = 3'b000;
    exp_in  = 8'h00;
    gf[0] = 8'h1F;
    gf[1] = 8'h1F;
    gf[2] = 8'h1F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 8'(busy_v[k]), 8'h00);
      chk("rst_done", k, 8'(done_v[k]), 8'h00);
      chk("rst_pass", k, 8'(pass_v[k]), 8'h00);
      chk("rst_tbl", k, tbl_v[k], 8'h00);
      chk("rst_inputs", k, 8'({in1_v[k], in2_v[k], in3_v[k]}), 8'h00);
    end
    reset = 1'b0;
    idle_chk(4);

    // 0x1F gate, S=4, matching and non-matching expected codes.
    sweep(0, 8'h1F, 0, 0, 0, 1'b0);
    chk("s4_tbl", 0, tbl_v[0], 8'h1F);
    chk("s4_pass", 0, 8'(pass_v[0]), 8'h01);
    idle_chk(4);
    sweep(0, 8'h1E, 0, 0, 0, 1'b0);
    chk("s4_tbl_1e", 0, tbl_v[0], 8'h1F);
    chk("s4_pass_1e", 0, 8'(pass_v[0]), 8'h00);
    idle_chk(4);

    // Gate output lags by two stages: S=1 misreads, S=3 settles.
    sweep(1, 8'h1F, 0, 0, 0, 1'b0);
    chk("s1_tbl", 1, tbl_v[1], 8'h07);
    chk("s1_pass", 1, 8'(pass_v[1]), 8'h00);
    idle_chk(4);
    sweep(2, 8'h1F, 0, 0, 0, 1'b0);
    chk("s3_tbl", 2, tbl_v[2], 8'h1F);
    chk("s3_pass", 2, 8'(pass_v[2]), 8'h01);
    idle_chk(4);

    // Abort in the middle of combination 4, then a fresh start clears the table.
    sweep(0, 8'h1F, 18, 0, 0, 1'b0);
    idle_chk(4);

    // Repeated start while busy, then reset during combination 5.
    sweep(0, 8'h1F, 0, 22, 10, 1'b0);
    idle_chk(4);

    // Start and abort together in IDLE; abort on the final sample edge.
    sweep(0, 8'h1F, 32, 0, 0, 1'b1);
    idle_chk(4);

    // Random gates, expected codes, aborts and redundant starts.
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(0, 2));
      gf[i] = 8'($urandom);
      idle_chk(4);
      mt = model_tbl(s_of(i), d_of(i), gf[i], 1000);
      ev = ($urandom_range(0, 1) == 1) ? mt : 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8 * s_of(i))) : 0;
      rst2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * s_of(i))) : 0;
      sweep(i, ev, ab, 0, rst2, 1'($urandom_range(0, 1)));
    end
    idle_chk(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
